// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared defaults, FSM encoding and width helpers for the
//               systolic matrix multiplier read-out path.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int unsigned c_N_DEFAULT  = 4;
    localparam int unsigned c_DW_DEFAULT = 16;

    // Result-drain FSM encoding: IDLE, WAIT, CAPTURE, DRAIN
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WAIT    = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;
    localparam logic [1:0] c_ST_DRAIN   = 2'd3;

    function automatic int unsigned f_lat(input int unsigned n);
        return 3 * n - 2;
    endfunction

    function automatic int unsigned f_clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int unsigned f_idx_w(input int unsigned n);
        return f_clog2_min1(n * n);
    endfunction

    function automatic int unsigned f_rc_w(input int unsigned n);
        return f_clog2_min1(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_snapshot.sv
`default_nettype none
// ============================================================================
// Module      : result_snapshot
// Description : N*N x DW register file, parallel load, one indexed read port.
// Revision    : 1.0 - initial release
// ============================================================================
module result_snapshot
    import systolic_pkg::*;
#(
    parameter int unsigned N  = c_N_DEFAULT,
    parameter int unsigned DW = c_DW_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_load,
    input  logic [N*N*DW-1:0]         i_load_data,
    input  logic [f_idx_w(N)-1:0]     i_rd_idx,
    output logic [DW-1:0]             o_rd_data
);

    logic [N*N*DW-1:0] r_mem;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem <= '0;
        end else if (i_load) begin
            r_mem <= i_load_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx*DW +: DW];

endmodule
`default_nettype wire

// File: rtl/result_drain.sv
`default_nettype none
// ============================================================================
// Module      : result_drain
// Description : Waits the array compute latency, snapshots all PE results and
//               streams them row-major over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module result_drain
    import systolic_pkg::*;
#(
    parameter int unsigned N   = c_N_DEFAULT,
    parameter int unsigned DW  = c_DW_DEFAULT,
    parameter int unsigned LAT = f_lat(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N*N*DW-1:0]         pe_result,
    output logic [DW-1:0]             out_data,
    output logic [f_rc_w(N)-1:0]      out_row,
    output logic [f_rc_w(N)-1:0]      out_col,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned     c_IW       = f_idx_w(N);
    localparam int unsigned     c_RW       = f_rc_w(N);
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(N * N - 1);
    localparam logic [c_RW-1:0] c_LAST_RC  = c_RW'(N - 1);
    localparam logic [7:0]      c_LAT8     = 8'(LAT);

    logic [1:0]      r_state;
    logic [7:0]      r_cnt;
    logic [c_IW-1:0] r_idx;
    logic [c_RW-1:0] r_row;
    logic [c_RW-1:0] r_col;
    logic [DW-1:0]   r_data;
    logic            r_valid;
    logic            r_last;
    logic            r_done;

    logic            w_snap_load;
    logic            w_hs;
    logic [c_IW-1:0] w_rd_idx;
    logic [DW-1:0]   w_rd_data;

    assign w_snap_load = (r_state == c_ST_CAPTURE);
    assign w_hs        = r_valid && out_ready;
    // The read port looks one element ahead so out_data can stay a register
    assign w_rd_idx    = r_idx + c_IW'(1);

    result_snapshot #(
        .N  (N),
        .DW (DW)
    ) u_snapshot (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_snap_load),
        .i_load_data (pe_result),
        .i_rd_idx    (w_rd_idx),
        .o_rd_data   (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_WAIT;
                        r_cnt   <= 8'd1;
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == c_LAT8) begin
                        r_state <= c_ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_ST_CAPTURE: begin
                    // Element 0 bypasses the snapshot, which loads on this same edge
                    r_state <= c_ST_DRAIN;
                    r_idx   <= '0;
                    r_row   <= '0;
                    r_col   <= '0;
                    r_data  <= pe_result[DW-1:0];
                    r_valid <= 1'b1;
                    r_last  <= 1'b0;
                end
                c_ST_DRAIN: begin
                    if (w_hs) begin
                        if (r_last) begin
                            r_state <= c_ST_IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx  <= w_rd_idx;
                            r_data <= w_rd_data;
                            r_last <= (w_rd_idx == c_LAST_IDX);
                            if (r_col == c_LAST_RC) begin
                                r_col <= '0;
                                r_row <= r_row + c_RW'(1);
                            end else begin
                                r_col <= r_col + c_RW'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign out_data  = r_data;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_drain
// Description : Directed self-checking bench for result_drain (N=4 and N=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_drain;

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         start     = 1'b0;
    logic         out_ready = 1'b1;
    logic [255:0] pe        = '0;
    logic [255:0] pe_saved;
    logic [15:0]  out_data;
    logic [1:0]   out_row;
    logic [1:0]   out_col;
    logic         out_valid;
    logic         out_last;
    logic         busy;
    logic         done;

    logic         start2     = 1'b0;
    logic         out_ready2 = 1'b1;
    logic [31:0]  pe2        = '0;
    logic [7:0]   out_data2;
    logic         out_row2;
    logic         out_col2;
    logic         out_valid2;
    logic         out_last2;
    logic         busy2;
    logic         done2;

    logic [7:0]   e6d [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic         e6r [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic         e6c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int t0          = 0;
    int fv;
    int dc;

    always #5 clk = ~clk;

    result_drain #(.N(4), .DW(16), .LAT(10)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pe_result (pe),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    result_drain #(.N(2), .DW(8), .LAT(4)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .pe_result (pe2),
        .out_data  (out_data2),
        .out_row   (out_row2),
        .out_col   (out_col2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_last  (out_last2),
        .busy      (busy2),
        .done      (done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Follows one N=4 run until done; expected element (r,c) is 16*r+c.
    task automatic drain(input logic stall, input logic inj, output int first_v, output int done_c);
        int cnt;
        cnt     = 0;
        first_v = -1;
        done_c  = -1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                done_c = cyc;
                chk("done_valid_low", out_valid, 0);
                chk("done_busy_low", busy, 0);
                chk("beat_count", cnt, 16);
                start = 1'b0;
                break;
            end
            out_ready = stall ? (i % 3 == 0) : 1'b1;
            start = inj && ((cyc == t0 + 5) || (cyc == t0 + 15) ||
                            (out_valid && out_last && out_ready));
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                chk("beat_overflow", cnt >= 16, 0);
                if (cnt < 16) begin
                    chk("beat_data", out_data, 16 * (cnt / 4) + (cnt % 4));
                    chk("beat_row", out_row, cnt / 4);
                    chk("beat_col", out_col, cnt % 4);
                    chk("beat_last", out_last, cnt == 15);
                end
                if (out_ready) cnt++;
            end
            tick();
        end
        chk("drain_done_seen", done_c >= 0, 1);
    endtask

    initial begin
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pe[(r*4+c)*16 +: 16] = 16'(16 * r + c);
        pe2 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        chk("rst2_valid", out_valid2, 0);
        chk("rst2_busy", busy2, 0);
        rst = 1'b1;
        tick();

        // Full-throughput run
        start = 1'b1; tick(); start = 1'b0; t0 = cyc;
        chk("t1_busy", busy, 1);
        chk("t1_valid_wait", out_valid, 0);
        drain(1'b0, 1'b0, fv, dc);
        chk("t1_first_beat", fv - t0, 11);
        chk("t1_done_cycle", dc - t0, 27);
        tick();
        chk("t1_done_one_cycle", done, 0);

        // Backpressure 1,0,0,1,...
        start = 1'b1; tick(); start = 1'b0; t0 = cyc;
        drain(1'b1, 1'b0, fv, dc);
        out_ready = 1'b1;
        chk("t2_first_beat", fv - t0, 11);
        tick();

        // Snapshot isolation
        start = 1'b1; tick(); start = 1'b0; t0 = cyc;
        while (cyc < t0 + 11) tick();
        pe_saved = pe;
        pe = ~pe;
        drain(1'b0, 1'b0, fv, dc);
        pe = pe_saved;
        chk("t3_done_cycle", dc - t0, 27);

        // Start while busy, then start in the done cycle
        tick();
        start = 1'b1; tick(); start = 1'b0; t0 = cyc;
        drain(1'b0, 1'b1, fv, dc);
        chk("t4_first_beat", fv - t0, 11);
        chk("t4_done_cycle", dc - t0, 27);
        start = 1'b1; tick(); start = 1'b0; t0 = cyc;
        chk("t4_single_done", done, 0);
        chk("t4_restart_busy", busy, 1);
        drain(1'b0, 1'b0, fv, dc);
        chk("t4_restart_first", fv - t0, 11);
        chk("t4_restart_done", dc - t0, 27);

        // Reset during the third drain beat
        tick();
        start = 1'b1; tick(); start = 1'b0; t0 = cyc;
        while (cyc < t0 + 13) tick();
        chk("t5_third_beat", out_data, 16'd2);
        rst = 1'b0; tick(); rst = 1'b1;
        chk("t5_busy", busy, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_done", done, 0);
        chk("t5_data", out_data, 0);
        chk("t5_row", out_row, 0);
        chk("t5_col", out_col, 0);
        chk("t5_last", out_last, 0);
        tick();
        chk("t5_no_done_after", done, 0);
        start = 1'b1; tick(); start = 1'b0; t0 = cyc;
        drain(1'b0, 1'b0, fv, dc);
        chk("t5_rerun_first", fv - t0, 11);
        chk("t5_rerun_done", dc - t0, 27);

        // N=2, DW=8, LAT=4
        tick();
        start2 = 1'b1; tick(); start2 = 1'b0; t0 = cyc;
        while (cyc < t0 + 4) tick();
        chk("t6_capture_valid", out_valid2, 0);
        chk("t6_capture_busy", busy2, 1);
        for (int b = 0; b < 4; b++) begin
            tick();
            chk("t6_valid", out_valid2, 1);
            chk("t6_data", out_data2, e6d[b]);
            chk("t6_row", out_row2, e6r[b]);
            chk("t6_col", out_col2, e6c[b]);
            chk("t6_last", out_last2, b == 3);
        end
        tick();
        chk("t6_done", done2, 1);
        chk("t6_done_valid", out_valid2, 0);
        chk("t6_done_at", cyc - t0, 9);
        tick();
        chk("t6_done_clear", done2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
